// File: rtl/tt_sweep_checker.sv
// Exhaustive truth-table sweeper: drives every stim index, captures dut_out, compares with a latched code.
// Latency: TT_WIDTH*(SETTLE+1)+1 busy cycles per sweep. Backpressure: none; start is ignored while busy.
module tt_sweep_checker #(
    parameter int N_IN     = 4,
    parameter int TT_WIDTH = 2**N_IN,
    parameter int SETTLE   = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [TT_WIDTH-1:0] expected_tt,
    input  logic                dut_out,
    output logic [N_IN-1:0]     stim,
    output logic                stim_valid,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [TT_WIDTH-1:0] captured_tt,
    output logic [N_IN:0]       fail_count,
    output logic [N_IN-1:0]     first_fail_idx
);
    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, FINISH} state_t;

    localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE > 0 ? SETTLE - 1 : 0);
    localparam logic [N_IN-1:0] IDX_LAST    = '1;
    localparam logic [N_IN-1:0] IDX_ONE     = 1;
    localparam logic [N_IN:0]   FC_ONE      = 1;
    // With no settle time a vector is just its SAMPLE cycle.
    localparam state_t          VEC_ENTRY   = (SETTLE == 0) ? SAMPLE : DRIVE;

    state_t              state, state_nxt;
    logic [N_IN-1:0]     idx, idx_nxt;
    logic [3:0]          settle_cnt, settle_cnt_nxt;
    logic [TT_WIDTH-1:0] exp_q, exp_q_nxt;
    logic [N_IN-1:0]     stim_nxt;
    logic                stim_valid_nxt, busy_nxt, done_nxt, pass_nxt;
    logic [TT_WIDTH-1:0] captured_tt_nxt;
    logic [N_IN:0]       fail_count_nxt;
    logic [N_IN-1:0]     first_fail_idx_nxt;

    always_comb begin
        state_nxt          = state;
        idx_nxt            = idx;
        settle_cnt_nxt     = settle_cnt;
        exp_q_nxt          = exp_q;
        stim_nxt           = stim;
        stim_valid_nxt     = stim_valid;
        busy_nxt           = busy;
        done_nxt           = done;
        pass_nxt           = pass;
        captured_tt_nxt    = captured_tt;
        fail_count_nxt     = fail_count;
        first_fail_idx_nxt = first_fail_idx;
        case (state)
            IDLE: begin
                if (start) begin
                    exp_q_nxt          = expected_tt;
                    idx_nxt            = '0;
                    settle_cnt_nxt     = '0;
                    stim_nxt           = '0;
                    stim_valid_nxt     = 1'b1;
                    busy_nxt           = 1'b1;
                    done_nxt           = 1'b0;
                    pass_nxt           = 1'b0;
                    captured_tt_nxt    = '0;
                    fail_count_nxt     = '0;
                    first_fail_idx_nxt = '0;
                    state_nxt          = VEC_ENTRY;
                end
            end
            DRIVE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    settle_cnt_nxt = '0;
                    state_nxt      = SAMPLE;
                end else begin
                    settle_cnt_nxt = settle_cnt + 4'd1;
                end
            end
            SAMPLE: begin
                // Index i lands in bit TT_WIDTH-1-i, which is ~i for a power-of-two width.
                captured_tt_nxt[~idx] = dut_out;
                if (dut_out != exp_q[~idx]) begin
                    fail_count_nxt = fail_count + FC_ONE;
                    if (fail_count == '0) begin
                        first_fail_idx_nxt = idx;
                    end
                end
                if (idx == IDX_LAST) begin
                    state_nxt = FINISH;
                end else begin
                    idx_nxt   = idx + IDX_ONE;
                    stim_nxt  = idx + IDX_ONE;
                    state_nxt = VEC_ENTRY;
                end
            end
            FINISH: begin
                stim_valid_nxt = 1'b0;
                busy_nxt       = 1'b0;
                done_nxt       = 1'b1;
                pass_nxt       = (fail_count == '0);
                stim_nxt       = '0;
                idx_nxt        = '0;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            idx            <= '0;
            settle_cnt     <= '0;
            exp_q          <= '0;
            stim           <= '0;
            stim_valid     <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            captured_tt    <= '0;
            fail_count     <= '0;
            first_fail_idx <= '0;
        end else begin
            state          <= state_nxt;
            idx            <= idx_nxt;
            settle_cnt     <= settle_cnt_nxt;
            exp_q          <= exp_q_nxt;
            stim           <= stim_nxt;
            stim_valid     <= stim_valid_nxt;
            busy           <= busy_nxt;
            done           <= done_nxt;
            pass           <= pass_nxt;
            captured_tt    <= captured_tt_nxt;
            fail_count     <= fail_count_nxt;
            first_fail_idx <= first_fail_idx_nxt;
        end
    end
endmodule

// File: tb/tb_tt_sweep_checker.sv
// Bench for tt_sweep_checker: SETTLE=1 instance against a lookup-table gate, SETTLE=0 instance against out=stim[3].
// Expected sweep results are queued when start is driven and compared when done rises.
module tb_tt_sweep_checker;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a, start_b;
    logic [15:0] exp_a, exp_b;
    logic [15:0] gate_a_tt;
    logic        dut_out_a, dut_out_b;
    logic [3:0]  stim_a, stim_b;
    logic        stim_valid_a, stim_valid_b, busy_a, busy_b, done_a, done_b, pass_a, pass_b;
    logic [15:0] captured_a, captured_b;
    logic [4:0]  fail_count_a, fail_count_b;
    logic [3:0]  first_fail_a, first_fail_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] tt;
        logic [4:0]  fc;
        logic [3:0]  ffi;
        logic        ps;
        int          cyc;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    assign dut_out_a = gate_a_tt[4'd15 - stim_a];
    assign dut_out_b = stim_b[3];

    tt_sweep_checker #(.N_IN(4), .TT_WIDTH(16), .SETTLE(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .expected_tt(exp_a), .dut_out(dut_out_a),
        .stim(stim_a), .stim_valid(stim_valid_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .captured_tt(captured_a), .fail_count(fail_count_a), .first_fail_idx(first_fail_a)
    );

    tt_sweep_checker #(.N_IN(4), .TT_WIDTH(16), .SETTLE(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .expected_tt(exp_b), .dut_out(dut_out_b),
        .stim(stim_b), .stim_valid(stim_valid_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .captured_tt(captured_b), .fail_count(fail_count_b), .first_fail_idx(first_fail_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic exp_t model(input logic [15:0] gate, input logic [15:0] code, input int settle);
        exp_t e;
        e.tt  = gate;
        e.fc  = '0;
        e.ffi = '0;
        for (int i = 0; i < 16; i++) begin
            if (gate[15-i] != code[15-i]) begin
                if (e.fc == 0) e.ffi = 4'(i);
                e.fc = e.fc + 5'd1;
            end
        end
        e.ps  = (e.fc == 0);
        e.cyc = 16 * (settle + 1) + 1;
        return e;
    endfunction

    task automatic check_zero(input string tag, input bit sel);
        check({tag, "_stim"},  32'(sel ? stim_b : stim_a), 0);
        check({tag, "_valid"}, 32'(sel ? stim_valid_b : stim_valid_a), 0);
        check({tag, "_busy"},  32'(sel ? busy_b : busy_a), 0);
        check({tag, "_done"},  32'(sel ? done_b : done_a), 0);
        check({tag, "_pass"},  32'(sel ? pass_b : pass_a), 0);
        check({tag, "_tt"},    32'(sel ? captured_b : captured_a), 0);
        check({tag, "_fc"},    32'(sel ? fail_count_b : fail_count_a), 0);
        check({tag, "_ffi"},   32'(sel ? first_fail_b : first_fail_a), 0);
    endtask

    // sel=1 uses the SETTLE=0 instance, whose gate is fixed to 0x00FF.
    task automatic run_sweep(input string tag, input bit sel, input logic [15:0] gate,
                             input logic [15:0] code, input bit disturb, input bit finish_poke);
        exp_t e;
        int   cyc;
        sb_q.push_back(model(gate, code, sel ? 0 : 1));
        if (!sel) gate_a_tt = gate;
        @(negedge clk);
        if (sel) begin start_b = 1'b1; exp_b = code; end
        else     begin start_a = 1'b1; exp_a = code; end
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        cyc = 0;
        while ((sel ? busy_b : busy_a) && cyc < 200) begin
            if (sel && cyc < 16) check({tag, "_stim_seq"}, 32'(stim_b), 32'(cyc));
            start_a = 1'b0;
            start_b = 1'b0;
            if (disturb && cyc == 10) begin
                start_a = 1'b1;
                exp_a   = ~code;
            end
            if (finish_poke && cyc == sb_q[0].cyc - 1) begin
                if (sel) start_b = 1'b1; else start_a = 1'b1;
            end
            cyc++;
            @(negedge clk);
        end
        start_a = 1'b0;
        start_b = 1'b0;
        e = sb_q.pop_front();
        check({tag, "_busy_cycles"}, 32'(cyc), 32'(e.cyc));
        check({tag, "_done"},  32'(sel ? done_b : done_a), 1);
        check({tag, "_pass"},  32'(sel ? pass_b : pass_a), 32'(e.ps));
        check({tag, "_tt"},    32'(sel ? captured_b : captured_a), 32'(e.tt));
        check({tag, "_fc"},    32'(sel ? fail_count_b : fail_count_a), 32'(e.fc));
        check({tag, "_ffi"},   32'(sel ? first_fail_b : first_fail_a), 32'(e.ffi));
        check({tag, "_valid"}, 32'(sel ? stim_valid_b : stim_valid_a), 0);
        @(negedge clk);
        check({tag, "_idle_after"}, 32'(sel ? busy_b : busy_a), 0);
        check({tag, "_hold_tt"},    32'(sel ? captured_b : captured_a), 32'(e.tt));
    endtask

    initial begin
        int guard;
        rst_n     = 1'b0;
        start_a   = 1'b0;
        start_b   = 1'b0;
        exp_a     = '0;
        exp_b     = '0;
        gate_a_tt = 16'h850E;
        #12;
        check_zero("rst_a", 1'b0);
        check_zero("rst_b", 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        run_sweep("g850e",   1'b0, 16'h850E, 16'h850E, 1'b0, 1'b0);
        run_sweep("g850e_x", 1'b0, 16'h850E, 16'h850F, 1'b0, 1'b0);
        run_sweep("tie0",    1'b0, 16'h0000, 16'hFFFF, 1'b0, 1'b0);
        run_sweep("id0",     1'b1, 16'h00FF, 16'h00FF, 1'b0, 1'b0);
        run_sweep("id0_x",   1'b1, 16'h00FF, 16'h0F0F, 1'b0, 1'b1);
        run_sweep("disturb", 1'b0, 16'h850E, 16'h850E, 1'b1, 1'b0);
        run_sweep("fin_poke", 1'b0, 16'h850E, 16'h850C, 1'b0, 1'b1);

        // Abort a sweep once idx reaches 7; partial results must vanish.
        gate_a_tt = 16'h850E;
        @(negedge clk);
        start_a = 1'b1;
        exp_a   = 16'h850E;
        @(negedge clk);
        start_a = 1'b0;
        guard   = 0;
        while (stim_a != 4'd7 && guard < 100) begin
            guard++;
            @(negedge clk);
        end
        check("reach_idx7", 32'(stim_a), 7);
        rst_n = 1'b0;
        #1;
        check_zero("midrst", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep("post_rst", 1'b0, 16'h850E, 16'h850E, 1'b0, 1'b0);

        check("sb_empty", 32'(sb_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tt_sweep_checker.md
Name: tt_sweep_checker

Overview:
Exhaustive truth-table stimulus generator and response checker for the 4-input synthesized logic gates, for example the 0x850E NOR/NOT netlist. It sits directly upstream of the gate under test. It drives every input combination in order, samples the gate output, assembles the observed truth table and compares it with an expected hex code. It is used in bring-up benches and in the on-chip self-check wrapper around each generated gate.

Parameters:
N_IN, 4, number of gate inputs; index width.
TT_WIDTH, 2**N_IN, truth-table width in bits (16 for N_IN=4).
SETTLE, 1, idle cycles after each stim change before sampling (0 allowed; range 0..15).

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  single-cycle request to begin a sweep; ignored while busy.
expected_tt  input  TT_WIDTH  expected truth-table code; latched on accepted start.
dut_out  input  1  gate under test output.
stim  output  N_IN  gate inputs; stim[N_IN-1] drives gate input _0, stim[0] drives the last input (_3).
stim_valid  output  1  high while stim holds a vector under test.
busy  output  1  sweep in progress.
done  output  1  level; high after a sweep completes, cleared by the next accepted start.
pass  output  1  valid when done; 1 iff captured_tt == latched expected_tt.
captured_tt  output  TT_WIDTH  observed truth table.
fail_count  output  N_IN+1  number of mismatching indices (0..TT_WIDTH).
first_fail_idx  output  N_IN  lowest mismatching index; 0 when fail_count==0.

Behaviour:
- Bit ordering (fixed codebase convention): the response to input index i (stim==i) lives in bit TT_WIDTH-1-i. Index 0 maps to the MSB of the hex code.
- Reset (async assert, sync release): FSM=IDLE; stim=0, stim_valid=0, busy=0, done=0, pass=0, captured_tt=0, fail_count=0, first_fail_idx=0, internal idx and settle counter=0.
- States:
  - IDLE -> DRIVE on start. On that edge: latch expected_tt, set idx=0, stim=0, stim_valid=1, busy=1, clear done, pass, captured_tt, fail_count and first_fail_idx.
  - DRIVE: count SETTLE cycles holding stim, then -> SAMPLE. With SETTLE=0, go directly to SAMPLE on the next edge.
  - SAMPLE (one cycle): at this edge, write dut_out into captured_tt[TT_WIDTH-1-idx] and compare it with the expected bit.
    - On mismatch: fail_count+=1. If this is the first mismatch, first_fail_idx=idx.
    - If idx==TT_WIDTH-1 -> FINISH. Otherwise idx+=1, stim=idx+1, -> DRIVE.
  - FINISH (one cycle): stim_valid=0, busy=0, done=1, pass=(fail_count==0 after the last update), stim returns to 0, -> IDLE.
- Timing: each vector occupies SETTLE+1 cycles (DRIVE plus SAMPLE). busy stays high for TT_WIDTH*(SETTLE+1)+1 cycles. done rises at the edge ending FINISH. For SETTLE=1 that is 33 busy cycles.
- Wrap and width rules:
  - idx never wraps during a sweep.
  - fail_count saturates naturally at TT_WIDTH (it is N_IN+1 bits wide).
  - stim is exactly idx; no gray coding.
- start while busy: ignored, no effect on state or the latch.
- start in the same cycle as FINISH: ignored, because busy is still high. A new start is accepted from IDLE on the following cycle.
- expected_tt changes during a sweep: no effect, because the latched copy is used.
- dut_out is treated as synchronous to clk. The block adds no synchronizer.
- Reset mid-sweep: immediate return to reset values. A partial captured_tt is discarded.
- captured_tt, fail_count and pass hold their values after done until the next accepted start.

Test Plan:
- Reset, then start with expected_tt=0x850E against a model of the 0x850E gate (SETTLE=1) -> 33 busy cycles, done=1, pass=1, captured_tt=0x850E, fail_count=0, first_fail_idx=0.
- Same gate with expected_tt=0x850F -> pass=0, fail_count=1, first_fail_idx=15, captured_tt=0x850E.
- dut_out tied 0 with expected_tt=0xFFFF -> fail_count=16, first_fail_idx=0, captured_tt=0x0000.
- SETTLE=0, identity-of-_0 gate (out=stim[3]) with expected_tt=0x00FF -> pass=1 after 17 busy cycles. The stim sequence observed is 0,1,...,15, each held 1 cycle.
- start pulsed mid-sweep plus expected_tt toggled mid-sweep -> the sweep is unchanged and the result matches the originally latched code.
- rst_n asserted at idx=7 -> all outputs return to 0 asynchronously. A subsequent start yields a clean full sweep with the correct result.
